// File: rtl/mem_arbiter.sv
// Arbitrates one main-memory block port between a read-only instruction cache
// and a read/write data cache, with round-robin tie-break and a grant watchdog.
module mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               M_READ,
  output logic               M_WRITE,
  output logic [ADDR_W-1:0]  M_ADDRESS,
  output logic [BLOCK_W-1:0] M_WRITEDATA,
  input  logic [BLOCK_W-1:0] M_READDATA,
  input  logic               M_BUSYWAIT,
  output logic               ERR
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, ACK_I, ACK_D} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic       last_d;     // 1 when the data cache owned the last grant
  logic       seen_busy;
  logic [7:0] wdog;

  logic       req_i, req_d;
  logic       grant_d;
  logic [7:0] wdog_next;
  logic       done, expired;

  assign req_i     = I_READ;
  assign req_d     = D_READ | D_WRITE;
  // On a tie the side that did not own the last grant wins.
  assign grant_d   = req_d & (~req_i | ~last_d);
  assign wdog_next = wdog + 8'd1;
  assign done      = seen_busy & ~M_BUSYWAIT;
  assign expired   = (wdog_next == TIMEOUT_CNT);

  assign I_BUSYWAIT = RESET & req_i & (state != ACK_I);
  assign D_BUSYWAIT = RESET & req_d & (state != ACK_D);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; the async reset drops the memory strobes at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      seen_busy   <= 1'b0;
      wdog        <= '0;
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_ADDRESS   <= '0;
      M_WRITEDATA <= '0;
      I_READDATA  <= '0;
      D_READDATA  <= '0;
      ERR         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i | req_d) begin
            seen_busy <= 1'b0;
            wdog      <= '0;
            if (grant_d) begin
              state       <= GNT_D;
              last_d      <= 1'b1;
              M_ADDRESS   <= D_ADDRESS;
              M_WRITEDATA <= D_WRITEDATA;
              M_WRITE     <= D_WRITE;
              M_READ      <= ~D_WRITE;
            end else begin
              state       <= GNT_I;
              last_d      <= 1'b0;
              M_ADDRESS   <= I_ADDRESS;
              M_WRITEDATA <= '0;
              M_WRITE     <= 1'b0;
              M_READ      <= 1'b1;
            end
          end
        end

        GNT_I, GNT_D: begin
          wdog <= wdog_next;
          if (M_BUSYWAIT) seen_busy <= 1'b1;
          if (done || expired) begin
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            state   <= (state == GNT_I) ? ACK_I : ACK_D;
            // Completion takes priority over a watchdog expiring on the same edge.
            if (!done) ERR <= 1'b1;
            if (state == GNT_I)
              I_READDATA <= done ? M_READDATA : '0;
            else if (M_READ)
              D_READDATA <= done ? M_READDATA : '0;
          end
        end

        ACK_I, ACK_D: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: latency-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int BW = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          I_READ = 1'b0;
  logic [AW-1:0] I_ADDRESS = '0;
  logic [BW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ = 1'b0;
  logic          D_WRITE = 1'b0;
  logic [AW-1:0] D_ADDRESS = '0;
  logic [BW-1:0] D_WRITEDATA = '0;
  logic [BW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          M_READ, M_WRITE;
  logic [AW-1:0] M_ADDRESS;
  logic [BW-1:0] M_WRITEDATA;
  logic [BW-1:0] M_READDATA;
  logic          M_BUSYWAIT;
  logic          ERR;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Memory: busy for mem_n cycles after a strobe appears (or forever when stuck).
  int            mem_n = 1;
  bit            mem_stuck = 1'b0;
  logic [BW-1:0] mem_rdata = '0;
  int            mem_cnt = 0;

  assign M_READDATA = mem_rdata;
  assign M_BUSYWAIT = (M_READ | M_WRITE) && (mem_stuck || mem_cnt < mem_n);
  always @(posedge CLK) mem_cnt <= (M_READ | M_WRITE) ? mem_cnt + 1 : 0;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference model: owner 0=none 1=I 2=D; a grant lasts a precomputed number of
  // edges (memory latency + 1, capped by the watchdog), then one ACK cycle.
  int            mo_owner = 0, mo_ack = 0, mo_cyc = 0, mo_limit = 0, done_at = 0;
  bit            mo_abort = 1'b0, mo_write = 1'b0, mo_last_d = 1'b0, take_d = 1'b0;
  logic [AW-1:0] mo_addr = '0;
  logic [BW-1:0] mo_wdata = '0, exp_i_rd = '0, exp_d_rd = '0;
  bit            exp_err = 1'b0;
  logic [31:0]   grant_seq = '0;  // one hex digit per grant: 1=I, 2=D

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mo_owner = 0; mo_ack = 0; mo_last_d = 1'b0; mo_write = 1'b0;
      exp_i_rd = '0; exp_d_rd = '0; exp_err = 1'b0;
    end else if (mo_ack != 0) begin
      mo_ack = 0;
    end else if (mo_owner != 0) begin
      mo_cyc++;
      if (mo_cyc == mo_limit) begin
        if (mo_abort) exp_err = 1'b1;
        if (mo_owner == 1) exp_i_rd = mo_abort ? '0 : mem_rdata;
        else if (!mo_write) exp_d_rd = mo_abort ? '0 : mem_rdata;
        mo_ack   = mo_owner;
        mo_owner = 0;
      end
    end else if (I_READ || D_READ || D_WRITE) begin
      take_d    = (D_READ || D_WRITE) && (!I_READ || !mo_last_d);
      mo_last_d = take_d;
      mo_owner  = take_d ? 2 : 1;
      mo_write  = take_d && D_WRITE;
      mo_addr   = take_d ? D_ADDRESS : I_ADDRESS;
      mo_wdata  = D_WRITEDATA;
      done_at   = (mem_stuck || mem_n == 0) ? TO + 1 : mem_n + 1;
      mo_abort  = done_at > TO;
      mo_limit  = mo_abort ? TO : done_at;
      mo_cyc    = 0;
      grant_seq = (grant_seq << 4) | (take_d ? 32'h2 : 32'h1);
    end
  end

  logic ex_r, ex_w;
  always @(negedge CLK) begin
    ex_r = RESET && (mo_owner == 1 || (mo_owner == 2 && !mo_write));
    ex_w = RESET && mo_owner == 2 && mo_write;
    check("m_read", 32'(M_READ), 32'(ex_r));
    check("m_write", 32'(M_WRITE), 32'(ex_w));
    if (mo_owner != 0) check("m_address", 32'(M_ADDRESS), 32'(mo_addr));
    if (ex_w) check("m_writedata", M_WRITEDATA, mo_wdata);
    check("i_busywait", 32'(I_BUSYWAIT), 32'(RESET && I_READ && mo_ack != 1));
    check("d_busywait", 32'(D_BUSYWAIT), 32'(RESET && (D_READ || D_WRITE) && mo_ack != 2));
    check("i_readdata", I_READDATA, exp_i_rd);
    check("d_readdata", D_READDATA, exp_d_rd);
    check("err", 32'(ERR), 32'(exp_err));
  end

  // Stimulus drives and samples 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int  n_mr, n_hi, n_lo, n_held, acks;
  bit  fin, d_done, saw_wr;

  initial begin
    #1 RESET = 1'b0;
    repeat (2) step();
    RESET = 1'b1;

    // Lone I read, memory busy 5 cycles.
    mem_n = 5; mem_rdata = 32'hDEADBEEF; I_ADDRESS = 6'h05; I_READ = 1'b1;
    n_mr = 0; n_hi = 0; n_lo = 0; fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      step();
      if (M_READ) n_mr++;
      if (D_BUSYWAIT) n_lo++;
      if (I_BUSYWAIT) n_hi++; else fin = 1'b1;
    end
    I_READ = 1'b0;
    check("t1_done", 32'(fin), 32'd1);
    check("t1_mread_cycles", n_mr, 32'd6);
    check("t1_stall_cycles", n_hi, 32'd6);
    check("t1_d_busywait", n_lo, 32'd0);
    check("t1_i_readdata", I_READDATA, 32'hDEADBEEF);

    // Simultaneous request after reset: D write wins first.
    RESET = 1'b0; step(); step(); RESET = 1'b1;
    mem_n = 3; I_ADDRESS = 6'h21; I_READ = 1'b1;
    D_WRITE = 1'b1; D_ADDRESS = 6'h0A; D_WRITEDATA = 32'h11223344;
    fin = 1'b0; d_done = 1'b0; saw_wr = 1'b0; n_lo = 0;
    for (int k = 0; k < 60 && !fin; k++) begin
      step();
      if (M_WRITE && M_WRITEDATA == 32'h11223344 && M_ADDRESS == 6'h0A) saw_wr = 1'b1;
      if (D_WRITE && !D_BUSYWAIT) begin D_WRITE = 1'b0; d_done = 1'b1; end
      if (!I_BUSYWAIT) begin
        n_lo++;
        fin = d_done;
        I_READ = 1'b0;
      end
    end
    check("t2_done", 32'(fin), 32'd1);
    check("t2_write_seen", 32'(saw_wr), 32'd1);
    check("t2_i_low_cycles", n_lo, 32'd1);
    check("t2_order", grant_seq & 32'hFF, 32'h21);

    // Round-robin with both sides requesting continuously.
    mem_n = 2; mem_rdata = 32'hCAFEF00D; D_ADDRESS = 6'h12; I_READ = 1'b1; D_READ = 1'b1;
    acks = 0;
    for (int k = 0; k < 100 && acks < 4; k++) begin
      step();
      if (!I_BUSYWAIT) acks++;
      if (!D_BUSYWAIT) acks++;
    end
    I_READ = 1'b0; D_READ = 1'b0;
    check("t3_acks", acks, 32'd4);
    check("t3_order", grant_seq & 32'hFFFF, 32'h2121);
    check("t3_d_readdata", D_READDATA, 32'hCAFEF00D);

    // Address change during a D grant is ignored.
    step();
    mem_n = 6; D_ADDRESS = 6'h0A; D_READ = 1'b1;
    step();
    D_ADDRESS = 6'h3F;
    n_held = 0; fin = 1'b0;
    if (M_READ && M_ADDRESS == 6'h0A) n_held++;
    for (int k = 0; k < 40 && !fin; k++) begin
      step();
      if (M_READ && M_ADDRESS == 6'h0A) n_held++;
      if (!D_BUSYWAIT) fin = 1'b1;
    end
    D_READ = 1'b0;
    check("t4_addr_held_cycles", n_held, 32'd7);

    // Watchdog: memory stuck busy on a D read.
    step();
    check("t5_err_before", 32'(ERR), 32'd0);
    mem_stuck = 1'b1; D_ADDRESS = 6'h11; D_READ = 1'b1;
    n_mr = 0; fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      step();
      if (M_READ) n_mr++;
      if (!D_BUSYWAIT) fin = 1'b1;
    end
    D_READ = 1'b0; mem_stuck = 1'b0;
    check("t5_done", 32'(fin), 32'd1);
    check("t5_grant_edges", n_mr, 32'd8);
    check("t5_err", 32'(ERR), 32'd1);
    check("t5_d_readdata", D_READDATA, 32'h0);

    // ERR stays set across a later good transaction.
    step();
    mem_n = 1; mem_rdata = 32'h5A5A5A5A; I_ADDRESS = 6'h07; I_READ = 1'b1;
    fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      step();
      if (!I_BUSYWAIT) fin = 1'b1;
    end
    I_READ = 1'b0;
    check("t6_i_readdata", I_READDATA, 32'h5A5A5A5A);
    check("t6_err_sticky", 32'(ERR), 32'd1);

    // Reset in the middle of an I grant.
    step();
    mem_n = 5; I_ADDRESS = 6'h03; I_READ = 1'b1;
    step(); step();
    check("t7_m_read_before", 32'(M_READ), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check("t7_m_read_reset", 32'(M_READ), 32'd0);
    check("t7_i_busywait_reset", 32'(I_BUSYWAIT), 32'd0);
    check("t7_err_reset", 32'(ERR), 32'd0);
    D_WRITE = 1'b1; D_ADDRESS = 6'h2C; D_WRITEDATA = 32'h0BADCAFE;
    step();
    RESET = 1'b1;
    acks = 0;
    for (int k = 0; k < 60 && acks < 2; k++) begin
      step();
      if (I_READ && !I_BUSYWAIT) begin acks++; I_READ = 1'b0; end
      if (D_WRITE && !D_BUSYWAIT) begin acks++; D_WRITE = 1'b0; end
    end
    check("t7_acks", acks, 32'd2);
    check("t7_order", grant_seq & 32'hFF, 32'h21);

    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
